// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: FSM states and control constants.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        STALL    = 2'b10,
        REDIRECT = 2'b11
    } pc_state_t;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;
    localparam logic BRANCH       = 1'b1;
    localparam logic NOT_BRANCH   = 1'b0;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one pending branch target until the next PC update consumes it.
module pc_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_target,
    input  logic              consume,
    input  logic              clear,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            target <= load_target;
        end else if (consume) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, branch capture during waits/stalls,
// and flush redirect with one-cycle bubble.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               fetch_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               fetch_req,
    output logic               pc_valid
);

    pc_state_t         state;
    logic [ADDR_W-1:0] next_pc;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              completion;
    logic              update;
    logic              active;
    logic              buf_load;
    logic              buf_clear;
    logic              unused_stall;

    // Only stall[0] has meaning; upper bits are accepted for interface compatibility.
    assign unused_stall = ^stall;

    always_comb begin
        active     = (state != IDLE);
        completion = (state == FETCH) && fetch_req && fetch_ack;
        update     = !flush &&
                     (((state == FETCH) && completion && (stall[0] == NO_STOP)) ||
                      ((state == STALL) && (stall[0] == NO_STOP)));
        buf_clear  = active && flush;
        buf_load   = active && !flush && !update && (branch_flag_i != NOT_BRANCH);

        if (branch_flag_i == BRANCH) begin
            next_pc = branch_target_address_i;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = pc + ADDR_W'(STEP);
        end
    end

    pc_redirect_buf #(
        .ADDR_W(ADDR_W)
    ) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .load_target(branch_target_address_i),
        .consume    (update),
        .clear      (buf_clear),
        .valid      (pend_valid),
        .target     (pend_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ce        <= CHIP_DISABLE;
            fetch_req <= 1'b0;
            pc_valid  <= 1'b0;
        end else begin
            pc_valid <= 1'b0;
            if (state == IDLE) begin
                state     <= FETCH;
                pc        <= RESET_PC;
                ce        <= CHIP_ENABLE;
                fetch_req <= 1'b1;
            end else if (flush) begin
                // Flush outranks ack, stall and branch; the completed fetch is dropped.
                state     <= REDIRECT;
                pc        <= new_pc;
                ce        <= CHIP_ENABLE;
                fetch_req <= 1'b0;
            end else begin
                ce <= CHIP_ENABLE;
                case (state)
                    FETCH: begin
                        if (completion) begin
                            pc_valid <= 1'b1;
                            if (stall[0] == STOP) begin
                                state     <= STALL;
                                fetch_req <= 1'b0;
                            end else begin
                                pc <= next_pc;
                            end
                        end
                    end
                    STALL: begin
                        if (stall[0] == NO_STOP) begin
                            state     <= FETCH;
                            pc        <= next_pc;
                            fetch_req <= 1'b1;
                        end
                    end
                    REDIRECT: begin
                        if (stall[0] == STOP) begin
                            state     <= STALL;
                            fetch_req <= 1'b0;
                        end else begin
                            state     <= FETCH;
                            fetch_req <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        fetch_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
